// File: rtl/icache.sv
// ============================================================================
//  Module   : icache
//  Purpose  : Direct-mapped instruction cache. Same-cycle hit lookup,
//             burst line refill from a multi-cycle backing memory using a
//             request/acknowledge handshake followed by read-valid beats.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module icache #(
  parameter int          SETS       = 16,
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        invalidate,
  output logic [31:0] instr,
  output logic        hit,
  output logic        miss_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int OFF  = $clog2(LINE_WORDS);
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 32 - IDX - OFF - 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2
  } state_t;

  state_t            r_state;
  logic [SETS-1:0]   r_valid;
  logic [TAGW-1:0]   r_tag  [SETS];
  logic [31:0]       r_data [SETS*LINE_WORDS];
  logic [TAGW-1:0]   r_fill_tag;
  logic [IDX-1:0]    r_fill_idx;
  logic [OFF-1:0]    r_beat;
  logic              r_mem_req;

  logic [OFF-1:0]    w_off;
  logic [IDX-1:0]    w_idx;
  logic [TAGW-1:0]   w_tag;
  logic              w_hit;
  logic              w_last_beat;
  logic              w_fill_we;
  logic              w_unused;

  // Address split of the fetch PC; the byte offset within a word is unused.
  assign w_off    = pc[OFF+1:2];
  assign w_idx    = pc[OFF+IDX+1:OFF+2];
  assign w_tag    = pc[31:OFF+IDX+2];
  assign w_unused = &{1'b0, pc[1:0]};

  assign w_hit       = !rst && (r_state == S_IDLE) && r_valid[w_idx] &&
                       (r_tag[w_idx] == w_tag);
  assign w_last_beat = (r_beat == OFF'(LINE_WORDS - 1));
  assign w_fill_we   = !rst && (r_state == S_FILL) && mem_rvalid;

  assign hit        = w_hit;
  assign instr      = w_hit ? r_data[{w_idx, w_off}] : NOP_INSTR;
  assign miss_stall = !rst && !w_hit;
  assign mem_req    = r_mem_req;

  // In IDLE the address tracks the current PC's line so it is already valid
  // in the miss cycle; afterwards it holds the latched line being refilled.
  always_comb begin
    mem_addr = '0;
    if (!rst) begin
      if (r_state == S_IDLE) mem_addr = {w_tag, w_idx, {(OFF+2){1'b0}}};
      else                   mem_addr = {r_fill_tag, r_fill_idx, {(OFF+2){1'b0}}};
    end
  end

  // Refill state machine: valid bits, latched line address, beat counter, request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_fill_tag <= '0;
      r_fill_idx <= '0;
      r_beat     <= '0;
      r_mem_req  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (invalidate) r_valid <= '0;
          // A miss under flush is dropped: that PC is about to be redirected.
          if (!w_hit && !flush) begin
            r_state    <= S_REQ;
            r_mem_req  <= 1'b1;
            r_fill_tag <= w_tag;
            r_fill_idx <= w_idx;
          end
        end
        S_REQ: begin
          // Acknowledge takes priority: once accepted, the burst is committed.
          if (mem_ack) begin
            r_state   <= S_FILL;
            r_beat    <= '0;
            r_mem_req <= 1'b0;
          end else if (flush) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
          end
        end
        S_FILL: begin
          if (mem_rvalid) begin
            r_beat <= r_beat + 1'b1;
            if (w_last_beat) begin
              r_valid[r_fill_idx] <= 1'b1;
              r_state             <= S_IDLE;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate their contents.
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_data[{r_fill_idx, r_beat}] <= mem_rdata;
      if (w_last_beat) r_tag[r_fill_idx] <= r_fill_tag;
    end
  end

endmodule

`default_nettype wire

// File: doc/icache.md
# icache

Direct-mapped instruction cache with a burst refill state machine that sits between the fetch PC register and the fetch/decode pipeline register. It replaces the single-cycle combinational instruction memory as the source of the fetched instruction. On a hit it returns the instruction in the same cycle. On a miss it raises a stall, fetches the whole line from a multi-cycle backing memory over a request/acknowledge plus read-valid handshake, installs the line and then hits.

## Interface
Parameters:
- SETS, 16, number of lines; power of two.
- LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.
- NOP_INSTR, 32'h00000013, value driven on instr when not hitting (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  fetch address; word-aligned, pc[1:0] ignored.
- flush  in  1  mispredict redirect from execute.
- invalidate  in  1  clear all valid bits (fence.i).
- instr  out  32  fetched instruction.
- hit  out  1  instr is valid this cycle.
- miss_stall  out  1  fetch must hold the PC and the fetch pipeline register.
- mem_req  out  1  line refill request to backing memory.
- mem_addr  out  32  line base address, low log2(LINE_WORDS)+2 bits zero.
- mem_ack  in  1  backing memory accepted the request.
- mem_rvalid  in  1  one refill word is present on mem_rdata.
- mem_rdata  in  32  refill data, delivered in ascending word order.

## Operation
Address split for the defaults:
- offset = pc[3:2]
- index = pc[7:4]
- tag = pc[31:8]
- Widths scale with the parameters (OFF = log2 LINE_WORDS, IDX = log2 SETS).

Storage:
- valid[SETS], cleared by reset.
- tag array and data array (SETS x LINE_WORDS words). Neither array is reset.

Lookup is combinational in IDLE:
- hit = valid[index] && tag match && state==IDLE && !rst.
- When hit: instr = data[index][offset] and miss_stall = 0.
- When not hit: instr = NOP_INSTR.
- miss_stall = !hit whenever state != IDLE, or when state==IDLE and the lookup misses. miss_stall is 0 while rst is high.

FSM states: IDLE, REQ, FILL.
- IDLE -> REQ on a miss with flush = 0. Latches line_addr = {tag, index, 0}. A miss with flush = 1 stays in IDLE, because that PC is about to be replaced.
- REQ: mem_req = 1 and mem_addr = line_addr, both held steady until mem_ack.
  - mem_ack -> FILL, with the beat counter cleared.
  - flush = 1 before mem_ack -> IDLE, with the request dropped (mem_req falls next cycle).
  - If flush and mem_ack are high in the same cycle, mem_ack wins and the state goes to FILL.
- FILL: each mem_rvalid writes mem_rdata into data[line index][beat] and increments the beat counter.
  - On beat LINE_WORDS-1: write the tag, set valid, go to IDLE.
  - flush is ignored in FILL. The committed burst always completes and the line is installed.
- mem_rvalid outside FILL is ignored.
- mem_req is 0 in IDLE and FILL.

Invalidate:
- Honoured only in IDLE: clears every valid bit at the edge.
- Ignored in REQ and FILL. The requester holds it until the stall clears.
- While invalidate is high in IDLE, the lookup still uses the old valid bits for the current cycle.

PC handling: pc may change during REQ or FILL (for example on a redirect). The fill uses the latched line_addr. After returning to IDLE, lookup uses the current pc.

## Timing
Reset values:
- State IDLE, beat counter 0, all valid bits 0.
- mem_req = 0, mem_addr = 0, hit = 0, miss_stall = 0, instr = NOP_INSTR.

Hit latency: 0 cycles (same-cycle combinational).

Miss timeline (miss seen in cycle 0):
- mem_req = 1 from cycle 1.
- With mem_ack in cycle 1 and beats in cycles 2..LINE_WORDS+1, state is IDLE in cycle LINE_WORDS+2 and the same pc hits there.
- Minimum miss penalty with the default LINE_WORDS is 6 cycles.

Backpressure: the backing memory may insert any number of cycles before mem_ack or between beats. The cache waits indefinitely.

Reset asserted mid-REQ or mid-FILL:
- Next cycle the state is IDLE, all lines are invalid and mem_req = 0.
- Outstanding beats are ignored.

## Test plan
- Cold miss: reset, pc=0x100, mem_ack in cycle 1, beats 0xA0..0xA3 in cycles 2-5.
  - Expect mem_addr=0x100 and miss_stall=1 in cycles 0-5.
  - Expect hit=1 with instr=0xA0 in cycle 6.
  - pc=0x10C then hits with instr=0xA3 and no request.
- Conflict miss: after the cold-miss fill, pc=0x200 (same index, new tag).
  - Expect a refill of 0x200.
  - pc=0x100 afterwards misses again.
- Flush in REQ: miss at 0x300, mem_ack withheld, flush in cycle 2.
  - Expect mem_req=0 in cycle 3 and state IDLE.
  - No line is installed; 0x300 still misses later.
- Flush in FILL: flush during beat 1 of a 0x400 fill.
  - The fill completes.
  - 0x400 hits afterwards without a new request.
- Invalidate: with lines 0x100 and 0x200 filled, pulse invalidate in IDLE.
  - Both addresses then miss.
  - Invalidate pulsed during FILL has no effect on the installed line.
- Reset mid-fill: assert rst after beat 2.
  - mem_req=0, hit=0 and miss_stall=0 while rst is high.
  - Stray mem_rvalid is ignored.
  - The old address misses after reset.
